imgproc_seq: RTL and testbench
==============================

# imgproc_seq

Raster-scan sequencer for the ImageProc 3x3 convolution datapath. Accepts the pixel-valid strobe from data capture, tracks column/row position, and drives line-buffer shift enables and border-suppressed window-valid. It aligns `output_valid` with the fixed datapath pipeline latency and latches kernel configuration only at frame boundaries. It sits between capture and ImageProc, replacing ad-hoc valid generation.

## Interface
- `WIDTH`, 640: active pixels per line (≥3)
- `HEIGHT`, 480: active lines per frame (≥3)
- `PIPE_LAT`, 3: datapath cycles from window-valid to result (≥1)
- `clk` in 1: single clock, all logic rising-edge
- `rst_n` in 1: asynchronous active-low reset
- `frame_start` in 1: one-cycle pulse, start of frame
- `pix_valid` in 1: `iDATA` carries a pixel this cycle
- `cfg_wr` in 1: write `cfg_mode` to pending register
- `cfg_mode` in 2: 0=gray passthrough, 1=Sobel-X, 2=Sobel-Y, 3=Sobel magnitude
- `lb_shift_en` out 1: shift line buffers / window this cycle
- `win_valid` out 1: 3x3 window holds a full interior neighbourhood
- `output_valid` out 1: `win_valid` delayed by `PIPE_LAT`
- `kernel_sel` out 2: active mode for current frame
- `col` out $clog2(WIDTH): column of the next expected pixel
- `row` out $clog2(HEIGHT): row of the next expected pixel
- `busy` out 1: state ≠ IDLE
- `frame_done` out 1: one-cycle pulse at end of frame
- `overrun_err` out 1: sticky flag for `frame_start` received while busy

## Operation
- States: IDLE → ACTIVE → FLUSH → DONE → IDLE.
- **IDLE**
  - `pix_valid` ignored.
  - On `frame_start`: clear `col`/`row`, load `kernel_sel` ← pending mode, go to ACTIVE.
- **ACTIVE**
  - `lb_shift_en = pix_valid` (combinational, 0 outside ACTIVE).
  - Each accepted pixel increments `col`; on `col==WIDTH-1`, `col`←0 and `row`++.
  - The accepted pixel at (`row`,`col`) with `row≥2 && col≥2` sets `win_valid` next cycle. Otherwise `win_valid`=0.
  - Gaps in `pix_valid` stall the counters; `win_valid` is 0 during gaps.
  - Accepting pixel (`HEIGHT-1`,`WIDTH-1`) → FLUSH. Counters hold at 0/0 (wrapped).
- **FLUSH**
  - Pixels ignored.
  - Stay until the delay line is empty, i.e. after the last `output_valid`, then go to DONE.
- **DONE**
  - `frame_done`=1 for one cycle, then IDLE.
- **Config**
  - `cfg_wr` updates the pending register in any state.
  - The pending register is applied only on an accepted `frame_start`.
  - `cfg_wr` and `frame_start` in the same cycle: the new `cfg_mode` is applied to that frame.
- **`frame_start` while busy**
  - Aborts the frame: counters cleared, delay line flushed to 0, pending mode loaded.
  - State goes to ACTIVE; `overrun_err` set (cleared only by reset).
  - No `frame_done` for the aborted frame.
- Interior outputs per frame: (WIDTH−2)·(HEIGHT−2).

## Timing
- Reset values:
  - `lb_shift_en`, `win_valid`, `output_valid`, `busy`, `frame_done`, `overrun_err` = 0
  - `col`, `row` = 0; `kernel_sel`, pending mode = 0; state = IDLE.
- Pixel accepted at cycle t:
  - `lb_shift_en` asserted at t.
  - `win_valid` asserted at t+1.
  - `output_valid` asserted at t+1+PIPE_LAT.
- Last pixel accepted at t:
  - FLUSH at t+1.
  - Last `output_valid` at t+1+PIPE_LAT.
  - `frame_done` at t+2+PIPE_LAT.
  - `busy` falls at t+3+PIPE_LAT.
- `frame_start` at t in IDLE: `busy` and `kernel_sel` update at t+1; a pixel at t+1 is accepted as (0,0).
- `frame_start` and `pix_valid` in the same IDLE cycle: the pixel is dropped.

## Structure
- `imgproc_pkg`:
  - `seq_state_t` enum (IDLE, ACTIVE, FLUSH, DONE)
  - `kernel_mode_t` enum (2-bit)
  - `KSIZE=3` constant
- Sub-module `valid_delay`:
  - Parameterised PIPE_LAT-deep shift register with synchronous clear and async reset.
  - Exposes `empty` for the FLUSH exit.

## Test plan
- **Basic frame.** WIDTH=8, HEIGHT=4, PIPE_LAT=2; `frame_start` then 32 back-to-back pixels.
  - Exactly 12 `win_valid` and 12 `output_valid` pulses.
  - First `win_valid` one cycle after pixel index 18.
  - `frame_done` 4 cycles after pixel 31.
- **Gapped input.** Same frame with `pix_valid` toggling 1,0.
  - Still 12 outputs; counters stall on gaps.
  - `frame_done` 4 cycles after the last pixel.
- **Config timing.**
  - `cfg_wr` mode=2 mid-frame → `kernel_sel` stays at its old value until the next `frame_start`, then becomes 2.
  - `cfg_wr` mode=1 in the same cycle as `frame_start` → `kernel_sel`=1 one cycle later.
- **Overrun.** `frame_start` after 10 pixels.
  - `overrun_err`=1; counters restart at 0.
  - No `frame_done` for the first frame.
  - The second frame completes with 12 outputs.
- **Idle pixels.** `pix_valid` asserted in IDLE → `lb_shift_en` stays 0 and the counters stay 0.
- **Reset mid-FLUSH.** `rst_n` low one cycle after the last pixel → all outputs take their reset values immediately; no `frame_done`.

Source files
------------

// File: rtl/imgproc_pkg.sv
// ---------------------------------------------------------------------------
// imgproc_pkg
// Shared types and constants for the ImageProc raster-scan sequencer.
//   seq_state_t   : sequencer FSM states
//   kernel_mode_t : convolution kernel selection (2-bit)
//   KSIZE         : convolution window edge length
// ---------------------------------------------------------------------------
package imgproc_pkg;

    localparam int KSIZE = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } seq_state_t;

    typedef enum logic [1:0] {
        MODE_GRAY      = 2'd0,
        MODE_SOBEL_X   = 2'd1,
        MODE_SOBEL_Y   = 2'd2,
        MODE_SOBEL_MAG = 2'd3
    } kernel_mode_t;

endpackage

// File: rtl/valid_delay.sv
// ---------------------------------------------------------------------------
// valid_delay
// PIPE_LAT-deep shift register carrying the window-valid strobe through the
// fixed datapath latency.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (drops every strobe in flight)
//   din        : strobe entering the pipeline
//   dout       : din delayed by PIPE_LAT cycles
//   empty      : no strobe will leave after the current cycle
// ---------------------------------------------------------------------------
module valid_delay #(
    parameter int PIPE_LAT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic din,
    output logic dout,
    output logic empty
);

    logic [PIPE_LAT-1:0] r_sr;
    logic                w_pending;

    generate
        if (PIPE_LAT == 1) begin : g_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sr <= '0;
                end else if (clr) begin
                    r_sr <= '0;
                end else begin
                    r_sr <= din;
                end
            end
            assign w_pending = 1'b0;
        end else begin : g_multi
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sr <= '0;
                end else if (clr) begin
                    r_sr <= '0;
                end else begin
                    r_sr <= {r_sr[PIPE_LAT-2:0], din};
                end
            end
            // Every stage except the output one still has a strobe to deliver.
            assign w_pending = |r_sr[PIPE_LAT-2:0];
        end
    endgenerate

    assign dout  = r_sr[PIPE_LAT-1];
    // The stage currently on dout is excluded: the line is considered drained
    // in the same cycle its last strobe appears on the output.
    assign empty = ~din & ~w_pending;

endmodule

// File: rtl/imgproc_seq.sv
// ---------------------------------------------------------------------------
// imgproc_seq
// Raster-scan sequencer for the 3x3 convolution datapath. Tracks pixel
// position, drives line-buffer shifts, flags interior windows, aligns the
// result strobe with the datapath latency and latches the kernel mode at
// frame start.
//   clk, rst_n              : clock, asynchronous active-low reset
//   frame_start             : one-cycle start-of-frame pulse
//   pix_valid               : a pixel is present this cycle
//   cfg_wr, cfg_mode        : write the pending kernel mode
//   lb_shift_en             : shift line buffers / window (combinational)
//   win_valid               : window holds a full interior neighbourhood
//   output_valid            : win_valid delayed by PIPE_LAT
//   kernel_sel              : kernel mode active for the current frame
//   col, row                : position of the next expected pixel
//   busy                    : sequencer not idle
//   frame_done              : one-cycle end-of-frame pulse
//   overrun_err             : sticky, frame_start seen while busy
// ---------------------------------------------------------------------------
module imgproc_seq
    import imgproc_pkg::*;
#(
    parameter int WIDTH    = 640,
    parameter int HEIGHT   = 480,
    parameter int PIPE_LAT = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      frame_start,
    input  logic                      pix_valid,
    input  logic                      cfg_wr,
    input  logic [1:0]                cfg_mode,
    output logic                      lb_shift_en,
    output logic                      win_valid,
    output logic                      output_valid,
    output logic [1:0]                kernel_sel,
    output logic [$clog2(WIDTH)-1:0]  col,
    output logic [$clog2(HEIGHT)-1:0] row,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      overrun_err
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(KSIZE - 1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(KSIZE - 1);

    seq_state_t    r_state, w_state_next;
    logic [CW-1:0] r_col, w_col_next;
    logic [RW-1:0] r_row, w_row_next;
    kernel_mode_t  r_pending, r_kernel_sel, w_mode_eff;
    logic          r_win_valid, w_win_next;
    logic          r_overrun;
    logic          w_accept, w_load_cfg, w_abort;
    logic          w_output_valid, w_dly_empty;

    // A write coinciding with frame_start goes straight into the new frame.
    assign w_mode_eff = cfg_wr ? kernel_mode_t'(cfg_mode) : r_pending;
    assign w_abort    = frame_start && (r_state != IDLE);

    always_comb begin
        w_state_next = r_state;
        w_col_next   = r_col;
        w_row_next   = r_row;
        w_accept     = 1'b0;
        w_win_next   = 1'b0;
        w_load_cfg   = 1'b0;
        if (frame_start) begin
            // Start from IDLE or restart an in-flight frame; a pixel in the
            // same cycle is dropped so the window never mixes two frames.
            w_load_cfg   = 1'b1;
            w_col_next   = '0;
            w_row_next   = '0;
            w_state_next = ACTIVE;
        end else begin
            case (r_state)
                ACTIVE: begin
                    if (pix_valid) begin
                        w_accept   = 1'b1;
                        w_win_next = (r_row >= ROW_MIN) && (r_col >= COL_MIN);
                        if (r_col == COL_LAST) begin
                            w_col_next = '0;
                            if (r_row == ROW_LAST) begin
                                w_row_next   = '0;
                                w_state_next = FLUSH;
                            end else begin
                                w_row_next = r_row + RW'(1);
                            end
                        end else begin
                            w_col_next = r_col + CW'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (w_dly_empty) begin
                        w_state_next = DONE;
                    end
                end
                DONE:    w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col        <= '0;
            r_row        <= '0;
            r_win_valid  <= 1'b0;
            r_pending    <= MODE_GRAY;
            r_kernel_sel <= MODE_GRAY;
            r_overrun    <= 1'b0;
        end else begin
            r_col       <= w_col_next;
            r_row       <= w_row_next;
            r_win_valid <= w_win_next;
            if (cfg_wr) begin
                r_pending <= kernel_mode_t'(cfg_mode);
            end
            if (w_load_cfg) begin
                r_kernel_sel <= w_mode_eff;
            end
            if (w_abort) begin
                r_overrun <= 1'b1;
            end
        end
    end

    valid_delay #(
        .PIPE_LAT (PIPE_LAT)
    ) u_valid_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_abort),
        .din   (r_win_valid),
        .dout  (w_output_valid),
        .empty (w_dly_empty)
    );

    assign lb_shift_en  = w_accept;
    assign win_valid    = r_win_valid;
    assign output_valid = w_output_valid;
    assign kernel_sel   = r_kernel_sel;
    assign col          = r_col;
    assign row          = r_row;
    assign busy         = (r_state != IDLE);
    assign frame_done   = (r_state == DONE);
    assign overrun_err  = r_overrun;

endmodule

// File: tb/tb_imgproc_seq.sv
// ---------------------------------------------------------------------------
// tb_imgproc_seq
// Self-checking bench for imgproc_seq with an 8x4 frame and PIPE_LAT=2.
// A per-cycle vector table covers reset, idle pixels, frame start and
// counter behaviour; hand-written sequences cover full frames, gaps,
// configuration timing, overrun and reset during FLUSH.
// ---------------------------------------------------------------------------
module tb_imgproc_seq;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int PL = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       pix_valid = 1'b0;
    logic       cfg_wr = 1'b0;
    logic [1:0] cfg_mode = 2'd0;
    logic       lb_shift_en, win_valid, output_valid, busy, frame_done, overrun_err;
    logic [1:0] kernel_sel;
    logic [2:0] col;
    logic [1:0] row;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Monitor-owned pulse logs
    int   n_win = 0, n_out = 0, n_done = 0;
    int   win_log[256];
    int   out_log[256];
    int   done_last = -1;
    int   fall_last = -1;
    logic busy_prev = 1'b0;

    int pix_cyc[32];

    typedef struct {
        int fs, pv, cw, mode;
        int e_lb, e_busy, e_ks, e_col, e_row, e_wv, e_ovr;
    } vec_t;
    vec_t vecs[10];

    imgproc_seq #(
        .WIDTH    (W),
        .HEIGHT   (H),
        .PIPE_LAT (PL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_start  (frame_start),
        .pix_valid    (pix_valid),
        .cfg_wr       (cfg_wr),
        .cfg_mode     (cfg_mode),
        .lb_shift_en  (lb_shift_en),
        .win_valid    (win_valid),
        .output_valid (output_valid),
        .kernel_sel   (kernel_sel),
        .col          (col),
        .row          (row),
        .busy         (busy),
        .frame_done   (frame_done),
        .overrun_err  (overrun_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (win_valid) begin
            if (n_win < 256) win_log[n_win] <= cyc;
            n_win <= n_win + 1;
        end
        if (output_valid) begin
            if (n_out < 256) out_log[n_out] <= cyc;
            n_out <= n_out + 1;
        end
        if (frame_done) begin
            n_done    <= n_done + 1;
            done_last <= cyc;
        end
        if (busy_prev && !busy) fall_last <= cyc;
        busy_prev <= busy;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input int fs, input int pv, input int cw, input int m);
        @(posedge clk);
        #1;
        frame_start = (fs != 0);
        pix_valid   = (pv != 0);
        cfg_wr      = (cw != 0);
        cfg_mode    = 2'(m);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        cfg_wr      = 1'b0;
        cfg_mode    = 2'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send_frame(input int first, input int n, input bit gapped);
        for (int i = first; i < first + n; i++) begin
            drive(0, 1, 0, 0);
            pix_cyc[i] = cyc;
            if (gapped && i == 10) begin
                chk("gap_stall_col", int'(col), 2);
                chk("gap_stall_row", int'(row), 1);
            end
            if (gapped) drive(0, 0, 0, 0);
        end
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 60) begin
            drive(0, 0, 0, 0);
            k++;
        end
        chk({name, "_idle_timeout"}, int'(busy), 0);
        @(negedge clk);
        #1;
    endtask

    initial begin
        int bw, bo, bd;

        vecs[0] = '{0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0};
        vecs[1] = '{0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0};
        vecs[2] = '{0, 1, 1, 3,  0, 0, 0, 0, 0, 0, 0};
        vecs[3] = '{1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0};
        vecs[4] = '{0, 1, 0, 0,  1, 1, 3, 0, 0, 0, 0};
        vecs[5] = '{0, 1, 0, 0,  1, 1, 3, 1, 0, 0, 0};
        vecs[6] = '{0, 0, 0, 0,  0, 1, 3, 2, 0, 0, 0};
        vecs[7] = '{0, 1, 0, 0,  1, 1, 3, 2, 0, 0, 0};
        vecs[8] = '{0, 1, 1, 2,  1, 1, 3, 3, 0, 0, 0};
        vecs[9] = '{0, 0, 0, 0,  0, 1, 3, 4, 0, 0, 0};

        // Per-cycle vector table
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].fs, vecs[i].pv, vecs[i].cw, vecs[i].mode);
            @(negedge clk);
            chk($sformatf("vec%0d_lb_shift_en", i), int'(lb_shift_en), vecs[i].e_lb);
            chk($sformatf("vec%0d_busy", i), int'(busy), vecs[i].e_busy);
            chk($sformatf("vec%0d_kernel_sel", i), int'(kernel_sel), vecs[i].e_ks);
            chk($sformatf("vec%0d_col", i), int'(col), vecs[i].e_col);
            chk($sformatf("vec%0d_row", i), int'(row), vecs[i].e_row);
            chk($sformatf("vec%0d_win_valid", i), int'(win_valid), vecs[i].e_wv);
            chk($sformatf("vec%0d_overrun", i), int'(overrun_err), vecs[i].e_ovr);
        end

        // Basic back-to-back frame
        do_reset();
        drive(1, 0, 0, 0);
        bw = n_win; bo = n_out; bd = n_done;
        send_frame(0, 32, 1'b0);
        drive(0, 0, 0, 0);
        wait_idle("basic");
        chk("basic_win_count", n_win - bw, 12);
        chk("basic_out_count", n_out - bo, 12);
        chk("basic_done_count", n_done - bd, 1);
        chk("basic_first_win_cyc", win_log[bw], pix_cyc[18] + 1);
        chk("basic_first_out_cyc", out_log[bo], pix_cyc[18] + 1 + PL);
        chk("basic_last_out_cyc", out_log[bo + 11], pix_cyc[31] + 1 + PL);
        chk("basic_done_cyc", done_last, pix_cyc[31] + 4);
        chk("basic_busy_fall_cyc", fall_last, pix_cyc[31] + 5);
        chk("basic_col_end", int'(col), 0);
        chk("basic_row_end", int'(row), 0);

        // Gapped frame
        do_reset();
        drive(1, 0, 0, 0);
        bw = n_win; bo = n_out; bd = n_done;
        send_frame(0, 32, 1'b1);
        wait_idle("gapped");
        chk("gapped_win_count", n_win - bw, 12);
        chk("gapped_out_count", n_out - bo, 12);
        chk("gapped_done_count", n_done - bd, 1);
        chk("gapped_first_win_cyc", win_log[bw], pix_cyc[18] + 1);
        chk("gapped_done_cyc", done_last, pix_cyc[31] + 4);

        // Config timing
        do_reset();
        drive(1, 0, 0, 0);
        send_frame(0, 16, 1'b0);
        drive(0, 0, 1, 2);
        send_frame(16, 16, 1'b0);
        chk("cfg_mid_frame_hold", int'(kernel_sel), 0);
        drive(0, 0, 0, 0);
        wait_idle("cfg1");
        chk("cfg_hold_after_frame", int'(kernel_sel), 0);
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("cfg_apply_next_frame", int'(kernel_sel), 2);
        send_frame(0, 32, 1'b0);
        drive(0, 0, 0, 0);
        wait_idle("cfg2");
        drive(1, 0, 1, 1);
        drive(0, 0, 0, 0);
        chk("cfg_same_cycle_start", int'(kernel_sel), 1);
        chk("cfg_no_overrun", int'(overrun_err), 0);

        // Overrun
        do_reset();
        drive(1, 0, 0, 0);
        bd = n_done;
        send_frame(0, 10, 1'b0);
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("ovr_flag", int'(overrun_err), 1);
        chk("ovr_col_restart", int'(col), 0);
        chk("ovr_row_restart", int'(row), 0);
        chk("ovr_busy", int'(busy), 1);
        bo = n_out;
        send_frame(0, 32, 1'b0);
        drive(0, 0, 0, 0);
        wait_idle("ovr");
        chk("ovr_done_count", n_done - bd, 1);
        chk("ovr_second_out_count", n_out - bo, 12);
        chk("ovr_sticky", int'(overrun_err), 1);

        // Reset during FLUSH
        do_reset();
        drive(0, 0, 1, 3);
        drive(1, 0, 0, 0);
        send_frame(0, 32, 1'b0);
        bd = n_done;
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        pix_valid = 1'b0;
        @(negedge clk);
        chk("rst_flush_busy", int'(busy), 0);
        chk("rst_flush_win_valid", int'(win_valid), 0);
        chk("rst_flush_output_valid", int'(output_valid), 0);
        chk("rst_flush_kernel_sel", int'(kernel_sel), 0);
        chk("rst_flush_col", int'(col), 0);
        chk("rst_flush_row", int'(row), 0);
        chk("rst_flush_frame_done", int'(frame_done), 0);
        chk("rst_flush_lb_shift_en", int'(lb_shift_en), 0);
        chk("rst_flush_overrun", int'(overrun_err), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) drive(0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("rst_flush_no_done", n_done - bd, 0);
        chk("rst_flush_idle", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
